// File: rtl/fp_div_arbiter.sv
// -----------------------------------------------------------------------------
// fp_div_arbiter
//
// Shares one pipelined single-precision FP divider among N_REQ requesters.
// A combinational round-robin picks at most one requester per cycle. The
// winner's ID goes into an in-order tag FIFO. Each quotient that comes back is
// routed to the requester whose tag is at the FIFO head.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    per-requester operand handshake (ready is one-hot or 0)
//   req_dataa/datab    packed operands, requester i at [32i+31:32i]
//   rsp_valid/ready    per-requester quotient handshake (valid is one-hot or 0)
//   rsp_data           quotient shared by all requesters
//   div_snk_*          operand handshake toward the divider
//   div_src_*          quotient handshake from the divider
//   outstanding        tag FIFO occupancy (divisions in flight)
//   err_orphan         sticky: the divider returned a result with no tag held
// -----------------------------------------------------------------------------
module fp_div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TAG_W   = 2,
  parameter int MAX_OUT = 40,
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_dataa,
  input  logic [32*N_REQ-1:0]  req_datab,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_data,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic                 div_snk_valid,
  output logic [31:0]          div_snk_dataa,
  output logic [31:0]          div_snk_datab,
  input  logic                 div_snk_ready,
  input  logic                 div_src_valid,
  input  logic [31:0]          div_src_data,
  output logic                 div_src_ready,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 err_orphan
);

  localparam int PTR_W = $clog2(MAX_OUT);

  // Tag FIFO storage and control
  logic [TAG_W-1:0] tag_mem [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [TAG_W-1:0] head;
  logic             empty;
  logic             not_full;

  // Arbitration
  logic [TAG_W-1:0] last_grant;
  logic [TAG_W-1:0] cand;
  logic [TAG_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant;
  logic             have_grant;
  logic             can_issue;
  logic             push;
  logic             pop;

  // Occupancy is the registered count, so a pop only frees a slot next cycle.
  assign empty     = (count == '0);
  assign not_full  = (count < CNT_W'(MAX_OUT));
  assign can_issue = div_snk_ready & not_full;

  // Round-robin: scan starting one past the last winner, wrapping mod N_REQ.
  // The grant is suppressed while reset is held so the request side reads
  // idle even if requesters keep their valids up.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    have_grant = 1'b0;
    cand       = '0;
    if (!rst) begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = TAG_W'((int'(last_grant) + k) % N_REQ);
        if (!have_grant && req_valid[cand]) begin
          have_grant      = 1'b1;
          grant_idx       = cand;
          grant[cand]     = 1'b1;
        end
      end
    end
  end

  // Operand mux from the granted requester; zero when nobody is granted.
  always_comb begin
    div_snk_dataa = '0;
    div_snk_datab = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant[j]) begin
        div_snk_dataa = req_dataa[32*j +: 32];
        div_snk_datab = req_datab[32*j +: 32];
      end
    end
  end

  // div_snk_valid does not wait for div_snk_ready; req_ready does.
  assign req_ready     = grant & {N_REQ{can_issue}};
  assign div_snk_valid = have_grant & not_full;
  assign push          = div_snk_valid & div_snk_ready;

  // Response routing. An empty FIFO blocks both the accept and any rsp_valid,
  // which is what keeps an orphan result from reaching a requester.
  assign head          = tag_mem[rd_ptr];
  assign div_src_ready = ~empty & rsp_ready[head];
  assign pop           = div_src_valid & div_src_ready;
  assign rsp_data      = div_src_data;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = div_src_valid & ~empty & (head == TAG_W'(i));
    end
  end

  assign outstanding = count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the tag storage has no reset. Entries are only read after being
  // written, because the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= TAG_W'(N_REQ - 1);
      err_orphan <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= ptr_inc(wr_ptr);
        last_grant <= grant_idx;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (div_src_valid && empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_div_arbiter
//
// Directed sequence with randomized operand choice. A behavioural divider
// (elastic queue, fixed latency, table-driven quotients) sits on the divider
// side. A scoreboard queue of (requester, quotient) in issue order checks
// every delivered response.
// -----------------------------------------------------------------------------
module tb_fp_div_arbiter;

  localparam int N    = 4;
  localparam int MAXO = 40;
  localparam int CW   = $clog2(MAXO + 1);
  localparam int LAT  = 33;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_dataa;
  logic [32*N-1:0] req_datab;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;
  logic [N-1:0]    rsp_ready;
  logic            div_snk_valid;
  logic [31:0]     div_snk_dataa;
  logic [31:0]     div_snk_datab;
  logic            div_snk_ready;
  logic            div_src_valid;
  logic [31:0]     div_src_data;
  logic            div_src_ready;
  logic [CW-1:0]   outstanding;
  logic            err_orphan;

  logic            src_v;
  logic [31:0]     src_d;
  logic            inj_orphan;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rsp = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  fp_div_arbiter #(.N_REQ(N), .TAG_W(2), .MAX_OUT(MAXO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_dataa     (req_dataa),
    .req_datab     (req_datab),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_ready     (rsp_ready),
    .div_snk_valid (div_snk_valid),
    .div_snk_dataa (div_snk_dataa),
    .div_snk_datab (div_snk_datab),
    .div_snk_ready (div_snk_ready),
    .div_src_valid (div_src_valid),
    .div_src_data  (div_src_data),
    .div_src_ready (div_src_ready),
    .outstanding   (outstanding),
    .err_orphan    (err_orphan)
  );

  // Operand table: dividend, divisor, IEEE-754 quotient.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
  } op_t;

  typedef struct {
    int          id;
    logic [31:0] q;
  } exp_t;

  typedef struct {
    logic [31:0] q;
    int          due;
  } fly_t;

  exp_t sb[$];
  fly_t dq[$];

  function automatic op_t op_tab(input int i);
    case (i)
      0:       return '{a: 32'h3F80_0000, b: 32'h4000_0000, q: 32'h3F00_0000}; // 1/2
      1:       return '{a: 32'h40C0_0000, b: 32'h4040_0000, q: 32'h4000_0000}; // 6/3
      2:       return '{a: 32'h3F80_0000, b: 32'h4080_0000, q: 32'h3E80_0000}; // 1/4
      3:       return '{a: 32'h4100_0000, b: 32'h4000_0000, q: 32'h4080_0000}; // 8/2
      4:       return '{a: 32'h4040_0000, b: 32'h4000_0000, q: 32'h3FC0_0000}; // 3/2
      default: return '{a: 32'h4120_0000, b: 32'h4080_0000, q: 32'h4020_0000}; // 10/4
    endcase
  endfunction

  function automatic logic [31:0] q_of(input logic [31:0] a, input logic [31:0] b);
    op_t o;
    for (int i = 0; i < 6; i++) begin
      o = op_tab(i);
      if (o.a == a && o.b == b) return o.q;
    end
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input int idx);
    op_t o;
    o = op_tab(idx);
    req_dataa[32*i +: 32] = o.a;
    req_datab[32*i +: 32] = o.b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, int'($urandom_range(0, 5)));
  endtask

  // Behavioural divider: accepts whenever div_snk_ready, result visible LAT
  // cycles after the accepting cycle, held until div_src_ready.
  assign div_src_valid = src_v | inj_orphan;
  assign div_src_data  = inj_orphan ? 32'hDEAD_BEEF : src_d;

  initial begin
    src_v = 1'b0;
    src_d = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        dq.delete();
        cyc = 0;
        src_v <= 1'b0;
        src_d <= '0;
      end else begin
        if (src_v && div_src_ready) void'(dq.pop_front());
        cyc = cyc + 1;
        if (div_snk_valid && div_snk_ready)
          dq.push_back('{q: q_of(div_snk_dataa, div_snk_datab), due: cyc + LAT - 1});
        if (dq.size() > 0 && dq[0].due <= cyc) begin
          src_v <= 1'b1;
          src_d <= dq[0].q;
        end else begin
          src_v <= 1'b0;
          src_d <= '0;
        end
      end
    end
  end

  // Scoreboard: responses must come back in issue order to the issuer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
      end else begin
        check("req_ready_onehot0", 64'($countones(req_ready) <= 1), 64'(1));
        check("rsp_valid_onehot0", 64'($countones(rsp_valid) <= 1), 64'(1));
        for (int i = 0; i < N; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            check("rsp_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check("rsp_id", 64'(i), 64'(e.id));
              check("rsp_data", 64'(rsp_data), 64'(e.q));
              n_rsp++;
            end
          end
        end
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i])
            sb.push_back('{id: i, q: q_of(req_dataa[32*i +: 32], req_datab[32*i +: 32])});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int found;
    int exp_idx;
    int n0;
    int stale;

    rst = 1'b1;
    req_valid = '0;
    req_dataa = '0;
    req_datab = '0;
    rsp_ready = '1;
    div_snk_ready = 1'b1;
    inj_orphan = 1'b0;

    // ---- Reset values ----
    sample();
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_snk_valid", 64'(div_snk_valid), 64'(0));
    check("rst_src_ready", 64'(div_src_ready), 64'(0));
    check("rst_dataa", 64'(div_snk_dataa), 64'(0));
    check("rst_datab", 64'(div_snk_datab), 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_err_orphan", 64'(err_orphan), 64'(0));
    tick();
    rst = 1'b0;

    // ---- Single request from requester 2 ----
    tick();
    set_op(2, 0);
    req_valid = 4'b0100;
    div_snk_ready = 1'b0;
    sample();
    check("t1_noready_req_ready", 64'(req_ready), 64'(0));
    check("t1_noready_snk_valid", 64'(div_snk_valid), 64'(1));
    tick();
    div_snk_ready = 1'b1;
    sample();
    check("t1_req_ready", 64'(req_ready), 64'(4'b0100));
    check("t1_dataa", 64'(div_snk_dataa), 64'(32'h3F80_0000));
    check("t1_datab", 64'(div_snk_datab), 64'(32'h4000_0000));
    tick();
    req_valid = '0;
    sample();
    check("t1_outstanding_1", 64'(outstanding), 64'(1));
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      sample();
      if (rsp_valid != '0) begin
        lat = k + 1;
        break;
      end
    end
    check("t1_latency", 64'(lat), 64'(LAT));
    check("t1_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check("t1_rsp_data", 64'(rsp_data), 64'(32'h3F00_0000));
    tick();
    sample();
    check("t1_outstanding_0", 64'(outstanding), 64'(0));

    // ---- All four valid for 8 cycles, 6.0/3.0 ----
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 1);
    req_valid = '1;
    n0 = n_rsp;
    exp_idx = N - 1;
    for (int k = 0; k < 8; k++) begin
      sample();
      exp_idx = (exp_idx + 1) % N;
      check("t2_grant", 64'(req_ready), 64'(1) << exp_idx);
      tick();
    end
    req_valid = '0;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      sample();
      if (outstanding == '0) begin
        found = 1;
        break;
      end
      tick();
    end
    check("t2_drained", 64'(found), 64'(1));
    check("t2_responses", 64'(n_rsp - n0), 64'(8));

    // ---- Backpressure on requester 1 ----
    tick();
    rsp_ready = 4'b1101;
    set_op(1, 3);
    req_valid = 4'b0010;
    sample();
    check("t3_issue", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = '0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      sample();
      if (rsp_valid != '0) begin
        found = 1;
        break;
      end
      tick();
    end
    check("t3_arrived", 64'(found), 64'(1));
    n0 = n_rsp;
    for (int k = 0; k < 10; k++) begin
      check("t3_hold_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
      check("t3_hold_src_ready", 64'(div_src_ready), 64'(0));
      check("t3_hold_data", 64'(rsp_data), 64'(32'h4080_0000));
      tick();
      sample();
    end
    tick();
    rsp_ready = '1;
    sample();
    check("t3_release_src_ready", 64'(div_src_ready), 64'(1));
    check("t3_release_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    tick();
    sample();
    check("t3_after_rsp_valid", 64'(rsp_valid), 64'(0));
    check("t3_after_outstanding", 64'(outstanding), 64'(0));
    check("t3_delivered_once", 64'(n_rsp - n0), 64'(1));

    // ---- FIFO full ----
    tick();
    rsp_ready = '0;
    req_valid = '1;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      rand_ops();
      sample();
      if (outstanding == CW'(MAXO)) begin
        found = 1;
        break;
      end
      tick();
    end
    check("t4_reached_full", 64'(found), 64'(1));
    check("t4_full_snk_valid", 64'(div_snk_valid), 64'(0));
    check("t4_full_req_ready", 64'(req_ready), 64'(0));
    tick();
    rsp_ready = '1;
    sample();
    check("t4_pop_src_ready", 64'(div_src_ready), 64'(1));
    check("t4_pop_same_cycle_snk_valid", 64'(div_snk_valid), 64'(0));
    check("t4_pop_same_cycle_req_ready", 64'(req_ready), 64'(0));
    tick();
    sample();
    check("t4_next_outstanding", 64'(outstanding), 64'(MAXO - 1));
    check("t4_next_snk_valid", 64'(div_snk_valid), 64'(1));
    check("t4_next_req_ready", 64'(req_ready != '0), 64'(1));
    tick();
    sample();
    check("t4_push_pop_outstanding", 64'(outstanding), 64'(MAXO - 1));
    tick();
    req_valid = '0;
    found = 0;
    for (int k = 0; k < 150; k++) begin
      sample();
      if (outstanding == '0) begin
        found = 1;
        break;
      end
      tick();
    end
    check("t4_drained", 64'(found), 64'(1));
    check("t4_sb_empty", 64'(sb.size()), 64'(0));

    // ---- Orphan result ----
    tick();
    inj_orphan = 1'b1;
    sample();
    check("t6_orphan_rsp_valid", 64'(rsp_valid), 64'(0));
    check("t6_orphan_src_ready", 64'(div_src_ready), 64'(0));
    tick();
    inj_orphan = 1'b0;
    sample();
    check("t6_err_set", 64'(err_orphan), 64'(1));
    for (int k = 0; k < 3; k++) tick();
    sample();
    check("t6_err_sticky", 64'(err_orphan), 64'(1));

    // ---- Reset with 5 divisions in flight ----
    tick();
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      sample();
      tick();
    end
    check("t5_inflight", 64'(outstanding), 64'(5));
    #1;
    rst = 1'b1;
    #1;
    check("t5_async_req_ready", 64'(req_ready), 64'(0));
    check("t5_async_snk_valid", 64'(div_snk_valid), 64'(0));
    check("t5_async_dataa", 64'(div_snk_dataa), 64'(0));
    check("t5_async_outstanding", 64'(outstanding), 64'(0));
    check("t5_async_rsp_valid", 64'(rsp_valid), 64'(0));
    check("t5_async_src_ready", 64'(div_src_ready), 64'(0));
    check("t5_async_err_orphan", 64'(err_orphan), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    req_valid = '0;
    n0 = n_rsp;
    stale = 0;
    for (int k = 0; k < 45; k++) begin
      sample();
      if (rsp_valid != '0) stale++;
      tick();
    end
    check("t5_no_stale_rsp", 64'(stale), 64'(0));
    check("t5_no_delivery", 64'(n_rsp - n0), 64'(0));
    check("t5_err_orphan", 64'(err_orphan), 64'(0));
    check("t5_outstanding", 64'(outstanding), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_div_arbiter.md
# fp_div_arbiter

Round-robin arbiter that shares one pipelined single-precision floating-point divider (valid/ready on both sides, fixed internal latency) among `N_REQ` requesters. It grants at most one division per cycle and records the winning requester ID in an in-order tag FIFO. When each quotient returns, it routes the quotient back to the requester that issued it. It sits between the video-processing engines that need division (normalisation, ratio computation) and the single divider instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TAG_W`, default 2: requester-ID width, equal to $clog2(N_REQ).
- `MAX_OUT`, default 40: tag FIFO depth, which is the maximum number of divisions in flight. Must be at least the divider latency (33) plus 2.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_dataa`  in  32*N_REQ  dividend for requester i, at bits [32i+31:32i].
- `req_datab`  in  32*N_REQ  divisor for requester i, at the same packing.
- `req_ready`  out  N_REQ  per-requester accept. At most one bit is high per cycle.
- `rsp_valid`  out  N_REQ  per-requester quotient valid. At most one bit is high per cycle.
- `rsp_data`  out  32  quotient, shared by all requesters and qualified by `rsp_valid`.
- `rsp_ready`  in  N_REQ  per-requester quotient accept.
- `div_snk_valid`  out  1  operand valid to the divider.
- `div_snk_dataa`  out  32  dividend to the divider.
- `div_snk_datab`  out  32  divisor to the divider.
- `div_snk_ready`  in  1  divider accepts an operand.
- `div_src_valid`  in  1  divider quotient valid.
- `div_src_data`  in  32  divider quotient.
- `div_src_ready`  out  1  accept from the divider.
- `outstanding`  out  $clog2(MAX_OUT+1)  current tag FIFO occupancy.
- `err_orphan`  out  1  sticky flag: the divider produced a result while no tag was held.

## Operation
- `can_issue` = `div_snk_ready` & (`outstanding` < `MAX_OUT`). Occupancy is the registered value; a pop in the same cycle does not free a slot until the next cycle.
- Grant selection:
  - Combinational round-robin over `req_valid`.
  - Search starts at `last_grant`+1, wraps modulo `N_REQ`, and takes the first valid requester.
  - `grant` is one-hot, or all zeros when no request is valid.
- Issue path:
  - `req_ready` = `grant` & {N_REQ{`can_issue`}}.
  - `div_snk_valid` = |`grant` & (`outstanding` < `MAX_OUT`).
  - `div_snk_dataa` and `div_snk_datab` are muxed from the granted requester, and are 0 when there is no grant.
- On issue (`div_snk_valid` & `div_snk_ready`):
  - Push the granted index into the tag FIFO.
  - `last_grant` <= granted index.
  - `last_grant` holds when there is no issue.
- Response routing:
  - `head` is the tag at the FIFO head.
  - `rsp_valid[i]` = `div_src_valid` & ~empty & (`head`==i).
  - `rsp_data` = `div_src_data`.
  - `div_src_ready` = ~empty & `rsp_ready[head]`.
  - Pop the FIFO on `div_src_valid` & `div_src_ready`.
- Orphan result (`div_src_valid` while the FIFO is empty):
  - Set `err_orphan`; it stays set until reset.
  - Hold `div_src_ready` low; no `rsp_valid` is asserted.
- Simultaneous push and pop: both take effect and `outstanding` is unchanged.
- Results leave in issue order (single divider, in-order FIFO). A stalled `rsp_ready` on the head requester blocks every requester's results. This is accepted head-of-line blocking.
- Reset mid-operation:
  - The FIFO empties, `outstanding`=0, `last_grant`=N_REQ-1, `err_orphan`=0.
  - The divider shares `rst`, so in-flight divisions are discarded. No response is produced for them, and requesters must re-issue.

## Timing
- Reset values: all `req_ready`, `rsp_valid` and `div_snk_valid` bits are 0. `div_src_ready`=0, `div_snk_dataa` and `div_snk_datab`=0, `outstanding`=0, `err_orphan`=0.
- The arbiter adds zero cycles of latency in both directions. The request-to-response latency equals the divider latency (33 cycles unloaded) plus any backpressure stall.
- Throughput: one issue per cycle while `can_issue` holds.
- Registered state: tag FIFO, `last_grant`, `err_orphan`.
- Combinational paths: `div_snk_ready` -> `req_ready`, and `rsp_ready` -> `div_src_ready`.
- Fairness: with all requesters continuously valid, each is granted exactly once every `N_REQ` issues.

## Test plan
- Single request after reset:
  - Stimulus: requester 2 issues 0x3F800000/0x40000000 (1.0/2.0).
  - Required: `req_ready[2]` high on the issue cycle; 33 cycles later `rsp_valid`=4'b0100 with `rsp_data`=0x3F000000; `outstanding` returns 0.
- All four requesters valid for 8 cycles, with operand 6.0/3.0 (0x40C00000/0x40400000):
  - Required grant order: 0,1,2,3,0,1,2,3.
  - Eight responses, each 0x40000000, routed in the same order.
- Backpressure:
  - Stimulus: hold `rsp_ready[1]`=0 for 10 cycles while requester 1's result is at the head.
  - Required: `div_src_ready`=0 and `rsp_valid[1]`=1 are held stable, no other `rsp_valid` bit rises, and the result is delivered once in the cycle `rsp_ready[1]`=1.
- FIFO full:
  - Stimulus: force `div_src_ready` to stall until `outstanding`=40.
  - Required: `div_snk_valid`=0 and all `req_ready`=0. The first pop re-enables issue on the following cycle, not the same cycle.
- Reset mid-operation:
  - Stimulus: assert `rst` with 5 divisions in flight.
  - Required: all outputs return to reset values asynchronously; no stale `rsp_valid` after release; `err_orphan`=0.
- Orphan injection:
  - Stimulus: drive `div_src_valid`=1 with the FIFO empty.
  - Required: `err_orphan`=1 next cycle and it stays set; all `rsp_valid`=0.
